// File: rtl/asip_pkg.sv
// rtl/asip_pkg.sv - shared types and constants for the ASIP pipeline
// Contents:
//   mem_state_t : memory-access stage FSM states
//   WB_SEL_MEM  : writeback select value choosing memory data
package asip_pkg;

  typedef enum logic {
    MS_IDLE = 1'b0,
    MS_REQ  = 1'b1
  } mem_state_t;

  localparam logic WB_SEL_MEM = 1'b1;

endpackage

// File: rtl/mem_timeout_ctr.sv
// rtl/mem_timeout_ctr.sv - saturating watchdog counter for the memory request
// Ports:
//   i_clock, i_reset : clock, asynchronous active-low reset
//   i_clear          : return the count to zero (has priority)
//   i_enable         : count one waiting cycle
//   o_expired        : count has reached TIMEOUT-1
module mem_timeout_ctr #(
  parameter int TIMEOUT = 64
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int W = $clog2(TIMEOUT) + 1;
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT - 1);

  logic [W-1:0] r_count;

  // Saturates at the abort point so a stuck enable never wraps back to zero.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != LIMIT)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = (r_count == LIMIT);

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - memory-access pipeline stage with req/ack data memory port
// Ports:
//   i_clock, i_reset          : clock, asynchronous active-low reset
//   i_valid_ex .. i_wdata_ex  : instruction fields from the EX/MEM register
//   o_dmem_req/we/addr/wdata  : data memory request, held stable during MS_REQ
//   i_dmem_ack, i_dmem_rdata  : one-cycle completion strobe and load data
//   o_stall_mem               : hold EX/MEM and earlier stages
//   o_*_mem                   : registered bundle to mem_wb_pipe
//   o_err_mem                 : sticky misalign / rd+wr conflict / timeout flag
module mem_access_stage
  import asip_pkg::*;
#(
  parameter int N       = 32,
  parameter int TIMEOUT = 64
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_valid_ex,
  input  logic         i_mem_rd_ex,
  input  logic         i_mem_wr_ex,
  input  logic         i_wr_en_ex,
  input  logic         i_wd_sel_ex,
  input  logic [4:0]   i_rw_ex,
  input  logic [N-1:0] i_alu_result_ex,
  input  logic [N-1:0] i_wdata_ex,
  output logic         o_dmem_req,
  output logic         o_dmem_we,
  output logic [N-1:0] o_dmem_addr,
  output logic [N-1:0] o_dmem_wdata,
  input  logic         i_dmem_ack,
  input  logic [N-1:0] i_dmem_rdata,
  output logic         o_stall_mem,
  output logic         o_wr_en_mem,
  output logic         o_wd_sel_mem,
  output logic [4:0]   o_rw_mem,
  output logic [N-1:0] o_alu_result_mem,
  output logic [N-1:0] o_rd_mem,
  output logic         o_err_mem
);

  mem_state_t r_state, w_next;

  // Holding registers for the outstanding transfer.
  logic         r_op_rd;
  logic         r_op_we;
  logic [N-1:0] r_addr;
  logic [N-1:0] r_wdata;
  logic         r_hold_wr_en;
  logic         r_hold_wd_sel;
  logic [4:0]   r_hold_rw;

  // Output registers towards mem_wb_pipe.
  logic         r_wr_en_mem;
  logic         r_wd_sel_mem;
  logic [4:0]   r_rw_mem;
  logic [N-1:0] r_alu_result_mem;
  logic [N-1:0] r_rd_mem;
  logic         r_err_mem;

  logic w_mem_op;
  logic w_illegal;
  logic w_pass;
  logic w_accept;
  logic w_bad;
  logic w_done;
  logic w_abort;
  logic w_stall;
  logic w_expired;

  assign w_mem_op  = i_mem_rd_ex | i_mem_wr_ex;
  assign w_illegal = (i_mem_rd_ex & i_mem_wr_ex) | (i_alu_result_ex[1:0] != 2'b00);

  mem_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_clear   (r_state == MS_IDLE),
    .i_enable  ((r_state == MS_REQ) && !i_dmem_ack),
    .o_expired (w_expired)
  );

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= MS_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_pass   = 1'b0;
    w_accept = 1'b0;
    w_bad    = 1'b0;
    w_done   = 1'b0;
    w_abort  = 1'b0;
    w_stall  = 1'b0;
    case (r_state)
      MS_IDLE: begin
        if (i_valid_ex) begin
          if (!w_mem_op) begin
            w_pass = 1'b1;
          end else if (w_illegal) begin
            w_bad = 1'b1;
          end else begin
            w_accept = 1'b1;
            w_stall  = 1'b1;
            w_next   = MS_REQ;
          end
        end
      end
      MS_REQ: begin
        // Ack is checked first so a same-cycle ack beats the watchdog.
        if (i_dmem_ack) begin
          w_done = 1'b1;
          w_next = MS_IDLE;
        end else if (w_expired) begin
          w_abort = 1'b1;
          w_next  = MS_IDLE;
        end else begin
          w_stall = 1'b1;
        end
      end
      default: begin
        w_next = MS_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_op_rd       <= 1'b0;
      r_op_we       <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_hold_wr_en  <= 1'b0;
      r_hold_wd_sel <= 1'b0;
      r_hold_rw     <= '0;
    end else if (w_accept) begin
      r_op_rd       <= i_mem_rd_ex;
      r_op_we       <= i_mem_wr_ex;
      r_addr        <= i_alu_result_ex;
      r_wdata       <= i_wdata_ex;
      r_hold_wr_en  <= i_wr_en_ex;
      r_hold_wd_sel <= i_wd_sel_ex;
      r_hold_rw     <= i_rw_ex;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_wr_en_mem      <= 1'b0;
      r_wd_sel_mem     <= 1'b0;
      r_rw_mem         <= '0;
      r_alu_result_mem <= '0;
      r_rd_mem         <= '0;
    end else if (w_pass) begin
      r_wr_en_mem      <= i_wr_en_ex;
      r_wd_sel_mem     <= i_wd_sel_ex;
      r_rw_mem         <= i_rw_ex;
      r_alu_result_mem <= i_alu_result_ex;
    end else if (w_done) begin
      r_wr_en_mem      <= r_hold_wr_en;
      r_wd_sel_mem     <= r_hold_wd_sel;
      r_rw_mem         <= r_hold_rw;
      r_alu_result_mem <= r_addr;
      if (r_op_rd) begin
        r_rd_mem <= i_dmem_rdata;
      end
    end else begin
      // Bubble: no writeback, select defaults away from memory data.
      r_wr_en_mem  <= 1'b0;
      r_wd_sel_mem <= ~WB_SEL_MEM;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_err_mem <= 1'b0;
    end else if (w_bad || w_abort) begin
      r_err_mem <= 1'b1;
    end
  end

  assign o_dmem_req       = (r_state == MS_REQ);
  assign o_dmem_we        = (r_state == MS_REQ) & r_op_we;
  assign o_dmem_addr      = r_addr;
  assign o_dmem_wdata     = r_wdata;
  assign o_stall_mem      = w_stall;
  assign o_wr_en_mem      = r_wr_en_mem;
  assign o_wd_sel_mem     = r_wd_sel_mem;
  assign o_rw_mem         = r_rw_mem;
  assign o_alu_result_mem = r_alu_result_mem;
  assign o_rd_mem         = r_rd_mem;
  assign o_err_mem        = r_err_mem;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed self-checking bench for mem_access_stage
module tb_mem_access_stage;
  import asip_pkg::*;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic        i_valid_ex, i_mem_rd_ex, i_mem_wr_ex, i_wr_en_ex, i_wd_sel_ex;
  logic [4:0]  i_rw_ex;
  logic [31:0] i_alu_result_ex, i_wdata_ex;
  logic        o_dmem_req, o_dmem_we;
  logic [31:0] o_dmem_addr, o_dmem_wdata;
  logic        i_dmem_ack;
  logic [31:0] i_dmem_rdata;
  logic        o_stall_mem, o_wr_en_mem, o_wd_sel_mem, o_err_mem;
  logic [4:0]  o_rw_mem;
  logic [31:0] o_alu_result_mem, o_rd_mem;

  int checks = 0;
  int errors = 0;

  mem_access_stage #(.N(32), .TIMEOUT(4)) dut (
    .i_clock          (i_clock),
    .i_reset          (i_reset),
    .i_valid_ex       (i_valid_ex),
    .i_mem_rd_ex      (i_mem_rd_ex),
    .i_mem_wr_ex      (i_mem_wr_ex),
    .i_wr_en_ex       (i_wr_en_ex),
    .i_wd_sel_ex      (i_wd_sel_ex),
    .i_rw_ex          (i_rw_ex),
    .i_alu_result_ex  (i_alu_result_ex),
    .i_wdata_ex       (i_wdata_ex),
    .o_dmem_req       (o_dmem_req),
    .o_dmem_we        (o_dmem_we),
    .o_dmem_addr      (o_dmem_addr),
    .o_dmem_wdata     (o_dmem_wdata),
    .i_dmem_ack       (i_dmem_ack),
    .i_dmem_rdata     (i_dmem_rdata),
    .o_stall_mem      (o_stall_mem),
    .o_wr_en_mem      (o_wr_en_mem),
    .o_wd_sel_mem     (o_wd_sel_mem),
    .o_rw_mem         (o_rw_mem),
    .o_alu_result_mem (o_alu_result_mem),
    .o_rd_mem         (o_rd_mem),
    .o_err_mem        (o_err_mem)
  );

  always #5 i_clock = ~i_clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic drive_ex(input logic v, input logic rd, input logic wr, input logic we,
                          input logic sel, input logic [4:0] rw, input logic [31:0] alu,
                          input logic [31:0] wd);
    i_valid_ex      = v;
    i_mem_rd_ex     = rd;
    i_mem_wr_ex     = wr;
    i_wr_en_ex      = we;
    i_wd_sel_ex     = sel;
    i_rw_ex         = rw;
    i_alu_result_ex = alu;
    i_wdata_ex      = wd;
  endtask

  task automatic idle_ex();
    drive_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    i_reset = 1'b0;
    tick();
    tick();
    i_reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL bench_timeout got=stuck exp=finish");
    $fatal(1);
  end

  initial begin
    i_reset      = 1'b0;
    i_dmem_ack   = 1'b0;
    i_dmem_rdata = 32'h0;
    idle_ex();
    tick();
    tick();
    chk("rst_req",   32'(o_dmem_req),   32'd0);
    chk("rst_stall", 32'(o_stall_mem),  32'd0);
    chk("rst_err",   32'(o_err_mem),    32'd0);
    chk("rst_wren",  32'(o_wr_en_mem),  32'd0);
    chk("rst_rw",    32'(o_rw_mem),     32'd0);
    chk("rst_alu",   o_alu_result_mem,  32'h0);
    chk("rst_rd",    o_rd_mem,          32'h0);
    chk("rst_addr",  o_dmem_addr,       32'h0);
    i_reset = 1'b1;
    tick();

    // ALU passthrough
    drive_ex(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5, 32'h1234, 32'h0);
    #1 chk("alu_stall", 32'(o_stall_mem), 32'd0);
    tick();
    idle_ex();
    #1;
    chk("alu_wren", 32'(o_wr_en_mem), 32'd1);
    chk("alu_rw",   32'(o_rw_mem),    32'd5);
    chk("alu_res",  o_alu_result_mem, 32'h1234);
    chk("alu_req",  32'(o_dmem_req),  32'd0);

    // Load, ack on third REQ cycle
    drive_ex(1'b1, 1'b1, 1'b0, 1'b1, WB_SEL_MEM, 5'd7, 32'h100, 32'h0);
    #1 chk("ld_stall_c0", 32'(o_stall_mem), 32'd1);
    for (int c = 1; c <= 3; c++) begin
      tick();
      idle_ex();
      if (c == 3) begin
        i_dmem_ack   = 1'b1;
        i_dmem_rdata = 32'hCAFEBABE;
      end
      #1;
      chk($sformatf("ld_req_c%0d", c),   32'(o_dmem_req),  32'd1);
      chk($sformatf("ld_addr_c%0d", c),  o_dmem_addr,      32'h100);
      chk($sformatf("ld_stall_c%0d", c), 32'(o_stall_mem), (c < 3) ? 32'd1 : 32'd0);
      chk($sformatf("ld_wren_c%0d", c),  32'(o_wr_en_mem), 32'd0);
    end
    tick();
    i_dmem_ack   = 1'b0;
    i_dmem_rdata = 32'h0;
    #1;
    chk("ld_rd",    o_rd_mem,          32'hCAFEBABE);
    chk("ld_wdsel", 32'(o_wd_sel_mem), 32'd1);
    chk("ld_rw",    32'(o_rw_mem),     32'd7);
    chk("ld_wren",  32'(o_wr_en_mem),  32'd1);
    chk("ld_alu",   o_alu_result_mem,  32'h100);
    chk("ld_req",   32'(o_dmem_req),   32'd0);

    // Store, immediate ack
    drive_ex(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd3, 32'h40, 32'hDEAD0001);
    tick();
    idle_ex();
    i_dmem_ack = 1'b1;
    #1;
    chk("st_req",   32'(o_dmem_req),  32'd1);
    chk("st_we",    32'(o_dmem_we),   32'd1);
    chk("st_wdata", o_dmem_wdata,     32'hDEAD0001);
    chk("st_addr",  o_dmem_addr,      32'h40);
    chk("st_stall", 32'(o_stall_mem), 32'd0);
    tick();
    i_dmem_ack = 1'b0;
    #1;
    chk("st_wren", 32'(o_wr_en_mem), 32'd0);
    chk("st_alu",  o_alu_result_mem, 32'h40);
    chk("st_rd",   o_rd_mem,         32'hCAFEBABE);
    chk("st_err",  32'(o_err_mem),   32'd0);

    // Timeout with TIMEOUT=4
    drive_ex(1'b1, 1'b1, 1'b0, 1'b1, WB_SEL_MEM, 5'd8, 32'h200, 32'h0);
    for (int c = 1; c <= 4; c++) begin
      tick();
      idle_ex();
      #1;
      chk($sformatf("to_req_c%0d", c),   32'(o_dmem_req),  32'd1);
      chk($sformatf("to_stall_c%0d", c), 32'(o_stall_mem), (c < 4) ? 32'd1 : 32'd0);
      chk($sformatf("to_err_c%0d", c),   32'(o_err_mem),   32'd0);
    end
    tick();
    chk("to_req_after", 32'(o_dmem_req),  32'd0);
    chk("to_err",       32'(o_err_mem),   32'd1);
    chk("to_wren",      32'(o_wr_en_mem), 32'd0);
    chk("to_rd",        o_rd_mem,         32'hCAFEBABE);
    drive_ex(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd9, 32'h55, 32'h0);
    tick();
    idle_ex();
    #1;
    chk("to_alu_wren", 32'(o_wr_en_mem), 32'd1);
    chk("to_alu_res",  o_alu_result_mem, 32'h55);
    chk("to_err_stk",  32'(o_err_mem),   32'd1);

    // Illegal: misaligned address, then rd+wr conflict
    for (int t = 0; t < 2; t++) begin
      do_reset();
      chk($sformatf("il%0d_err0", t), 32'(o_err_mem), 32'd0);
      drive_ex(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd4, 32'h10, 32'h0);
      tick();
      if (t == 0) drive_ex(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd6, 32'h102, 32'h0);
      else        drive_ex(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'd6, 32'h100, 32'h0);
      #1;
      chk($sformatf("il%0d_stall", t), 32'(o_stall_mem), 32'd0);
      chk($sformatf("il%0d_pre_wren", t), 32'(o_wr_en_mem), 32'd1);
      tick();
      idle_ex();
      #1;
      chk($sformatf("il%0d_req", t),  32'(o_dmem_req),  32'd0);
      chk($sformatf("il%0d_err", t),  32'(o_err_mem),   32'd1);
      chk($sformatf("il%0d_wren", t), 32'(o_wr_en_mem), 32'd0);
    end

    // Reset in the second REQ cycle
    do_reset();
    drive_ex(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5, 32'h1234, 32'h0);
    tick();
    drive_ex(1'b1, 1'b1, 1'b0, 1'b1, WB_SEL_MEM, 5'd2, 32'h300, 32'h0);
    tick();
    idle_ex();
    tick();
    #1 chk("mr_req_pre", 32'(o_dmem_req), 32'd1);
    i_reset = 1'b0;
    #1;
    chk("mr_req",   32'(o_dmem_req),  32'd0);
    chk("mr_stall", 32'(o_stall_mem), 32'd0);
    chk("mr_wren",  32'(o_wr_en_mem), 32'd0);
    chk("mr_rw",    32'(o_rw_mem),    32'd0);
    chk("mr_alu",   o_alu_result_mem, 32'h0);
    chk("mr_addr",  o_dmem_addr,      32'h0);
    tick();
    i_reset      = 1'b1;
    i_dmem_ack   = 1'b1;
    i_dmem_rdata = 32'h12345678;
    #1 chk("mr_ack_stall", 32'(o_stall_mem), 32'd0);
    tick();
    i_dmem_ack = 1'b0;
    #1;
    chk("mr_late_req",  32'(o_dmem_req),  32'd0);
    chk("mr_late_rd",   o_rd_mem,         32'h0);
    chk("mr_late_wren", 32'(o_wr_en_mem), 32'd0);
    chk("mr_late_err",  32'(o_err_mem),   32'd0);
    tick();
    chk("mr_idle_req", 32'(o_dmem_req), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage of the RSA-decryption ASIP pipeline, between the EX/MEM pipe register and `mem_wb_pipe`. It performs word loads and stores against the data memory through a req/ack handshake and stalls upstream while a transfer is outstanding. It drives the `*_mem` signal bundle consumed by `mem_wb_pipe`, inserting a bubble whenever no instruction completes. A timeout watchdog and sticky error flag protect against a hung memory.

## Interface
- `N`, 32: data and address width.
- `TIMEOUT`, 64: maximum cycles in REQ without ack before abort; minimum 1.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `valid_ex` in 1: EX/MEM holds a live instruction.
- `mem_rd_ex`, `mem_wr_ex` in 1: load / store request.
- `wr_en_ex`, `wd_sel_ex` in 1: writeback enable / select (1 = memory data).
- `rw_ex` in 5: destination register.
- `alu_result_ex` in N: ALU result, also the memory address.
- `wdata_ex` in N: store data.
- `dmem_req` out 1: memory request.
- `dmem_we` out 1: 1 = write.
- `dmem_addr` out N: word-aligned address.
- `dmem_wdata` out N: store data.
- `dmem_ack` in 1: one-cycle completion strobe.
- `dmem_rdata` in N: load data, valid with `dmem_ack`.
- `stall_mem` out 1: hold EX/MEM and all earlier stages.
- `wr_en_mem`, `wd_sel_mem` out 1: to `mem_wb_pipe`.
- `rw_mem` out 5: to `mem_wb_pipe`.
- `alu_result_mem`, `rd_mem` out N: to `mem_wb_pipe`.
- `err_mem` out 1: sticky error (misaligned, rd+wr conflict, or timeout).

## Operation
- **FSM states:** MS_IDLE, MS_REQ.
- **MS_IDLE, valid non-memory op:** register `wr_en_ex`/`wd_sel_ex`/`rw_ex`/`alu_result_ex` to the outputs. `rd_mem` holds its previous value. `stall_mem`=0.
- **MS_IDLE, valid legal memory op:** latch op, address, wdata and control into holding registers. `stall_mem`=1 combinationally. Next state MS_REQ. Outputs get a bubble (`wr_en_mem`=0).
- **Illegal memory op:** `mem_rd_ex & mem_wr_ex`, or `alu_result_ex[1:0]`≠0. No request is issued, `err_mem` is set, a bubble is emitted, and the FSM stays in MS_IDLE with no stall.
- **MS_REQ:**
  - `dmem_req`=1; `dmem_we`, `dmem_addr` and `dmem_wdata` come from the holding registers and are stable for the whole state.
  - While waiting for ack: `stall_mem`=1 and bubble.
  - On `dmem_ack`: `stall_mem`=0 in that cycle. Next edge outputs the held control and `alu_result`; `rd_mem` = `dmem_rdata` for a load, unchanged for a store. Return to MS_IDLE.
- **Timeout:** a counter clears on MS_REQ entry and increments each MS_REQ cycle without ack. When it reaches `TIMEOUT`-1 with no ack: drop `dmem_req` next cycle, set `err_mem`, emit a bubble (aborted op is discarded), `stall_mem`=0 in that cycle, go to MS_IDLE.
- **Ack and timeout in the same cycle:** ack wins; no error.
- **Ack in MS_IDLE:** ignored.
- **`valid_ex`=0 in MS_IDLE:** bubble.
- **`err_mem`:** cleared only by reset.
- **Counter width:** $clog2(`TIMEOUT`)+1. No wrap; saturates at the abort point.

## Timing
- **Non-memory op:** 1-cycle latency, edge to outputs.
- **Load/store:** accept at cycle 0; `dmem_req` high from cycle 1. An ack at cycle k (k≥1) gives outputs valid after the edge ending cycle k.
- **Minimum memory latency:** 2 cycles.
- **`stall_mem`:** high in cycles 0..k-1, low in cycle k.
- **Reset (asserted):**
  - FSM → MS_IDLE immediately (asynchronous).
  - `dmem_req`, `dmem_we`, `stall_mem`, `err_mem`, `wr_en_mem`, `wd_sel_mem` = 0.
  - `rw_mem` = 0; `alu_result_mem`, `rd_mem`, `dmem_addr`, `dmem_wdata` = 0.
  - Counter = 0.
  - Mid-transaction reset abandons the request; a late ack after reset release is ignored.

## Structure
- **Shared package `asip_pkg`:** enum `mem_state_t` {MS_IDLE, MS_REQ}; constant `WB_SEL_MEM`=1'b1.
- **Sub-module `mem_timeout_ctr`:**
  - Parameter `TIMEOUT`.
  - Inputs: `clear`, `enable`.
  - Output: `expired`.
  - Uses the same clock and reset as the stage.
- **FSM, holding registers and output registers:** in the top module.

## Test plan
- **ALU passthrough:** `valid_ex`=1, no memory op, `rw_ex`=5, `alu_result_ex`=0x1234, `wr_en_ex`=1 → next cycle `wr_en_mem`=1, `rw_mem`=5, `alu_result_mem`=0x1234, no stall.
- **Load, 3-cycle wait:** load from address 0x100, `rw_ex`=7; ack with `dmem_rdata`=0xCAFEBABE on the 3rd REQ cycle.
  - `stall_mem` high for 3 cycles and low on the ack cycle; `dmem_addr`=0x100 throughout.
  - Next cycle: `rd_mem`=0xCAFEBABE, `wd_sel_mem`=1, `rw_mem`=7, `wr_en_mem`=1.
- **Store with immediate ack:** address 0x40, data 0xDEAD0001 → `dmem_we`=1 and `dmem_wdata`=0xDEAD0001 in cycle 1; outputs in cycle 2 with `wr_en_mem`=0 (from `wr_en_ex`=0); `rd_mem` unchanged.
- **Timeout:** `TIMEOUT`=4, load, no ack → `dmem_req` high for 4 cycles, then 0; `err_mem`=1 and sticky; bubble emitted; next ALU op proceeds normally.
- **Illegal ops:** address 0x102 → no `dmem_req`, `err_mem`=1, bubble, no stall. `mem_rd_ex`=`mem_wr_ex`=1 → same response.
- **Reset mid-REQ:** assert reset in the 2nd REQ cycle → `dmem_req` and `stall_mem` drop immediately and all outputs are 0. An ack after release is ignored, and the FSM stays in MS_IDLE.
